// File: rtl/pmesh_msg_pkg.sv
// P-Mesh message types, header field offsets and initiator FSM states.
// Shared by the store/load request initiator and its header codec.
package pmesh_msg_pkg;

  localparam logic [7:0] MSG_STORE_REQ  = 8'd2;
  localparam logic [7:0] MSG_LOAD_REQ   = 8'd31;
  localparam logic [7:0] MSG_DATA_ACK   = 8'd36;
  localparam logic [7:0] MSG_NODATA_ACK = 8'd37;

  localparam int HDR_X_LSB    = 56;
  localparam int HDR_Y_LSB    = 48;
  localparam int HDR_LEN_LSB  = 22;
  localparam int HDR_TYPE_LSB = 14;
  localparam int HDR_MSHR_LSB = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_HDR,
    ST_TX_ADDR,
    ST_TX_DATA,
    ST_WAIT_HDR,
    ST_RX_DATA,
    ST_DONE
  } state_e;

  function automatic logic [7:0] ack_type(input logic is_store);
    return is_store ? MSG_NODATA_ACK : MSG_DATA_ACK;
  endfunction

  function automatic logic [7:0] req_len(input logic is_store);
    return is_store ? 8'd2 : 8'd1;
  endfunction

endpackage

// File: rtl/noc_hdr_codec.sv
// Combinational P-Mesh header encoder (request side) and
// decoder (response side).
module noc_hdr_codec
  import pmesh_msg_pkg::*;
#(
  parameter logic [7:0] DEST_X = 8'd0,
  parameter logic [7:0] DEST_Y = 8'd0
) (
  input  logic [7:0]  enc_len_i,
  input  logic [7:0]  enc_type_i,
  input  logic [7:0]  enc_mshrid_i,
  output logic [63:0] hdr_o,
  input  logic [63:0] flit_i,
  output logic [7:0]  dec_len_o,
  output logic [7:0]  dec_type_o,
  output logic [7:0]  dec_mshrid_o
);

  always_comb begin
    hdr_o = '0;
    hdr_o[HDR_X_LSB    +: 8] = DEST_X;
    hdr_o[HDR_Y_LSB    +: 8] = DEST_Y;
    hdr_o[HDR_LEN_LSB  +: 8] = enc_len_i;
    hdr_o[HDR_TYPE_LSB +: 8] = enc_type_i;
    hdr_o[HDR_MSHR_LSB +: 8] = enc_mshrid_i;
  end

  assign dec_len_o    = flit_i[HDR_LEN_LSB  +: 8];
  assign dec_type_o   = flit_i[HDR_TYPE_LSB +: 8];
  assign dec_mshrid_o = flit_i[HDR_MSHR_LSB +: 8];

  // Routing and reserved bits carry nothing the initiator acts on.
  logic unused_bits;
  assign unused_bits = ^{flit_i[63:30], flit_i[5:0]};

endmodule

// File: rtl/store_req_initiator.sv
// Single-outstanding store/load request initiator: sends a request
// over NoC1, waits for the L2 reply on NoC2, reports completion.
module store_req_initiator
  import pmesh_msg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [7:0]  DEST_X = 8'd0,
  parameter logic [7:0]  DEST_Y = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_type,
  input  logic [39:0] cmd_addr,
  input  logic [63:0] cmd_data,
  input  logic [7:0]  cmd_mshrid,
  output logic        noc1_valid,
  output logic [63:0] noc1_data,
  input  logic        noc1_ready,
  input  logic        noc2_valid,
  input  logic [63:0] noc2_data,
  output logic        noc2_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_type,
  output logic [7:0]  rsp_mshrid,
  output logic [63:0] rsp_data,
  output logic        rsp_timeout,
  output logic        rsp_err
);

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_e      state_q;
  logic [7:0]  type_q;
  logic [7:0]  mshr_q;
  logic [39:0] addr_q;
  logic [63:0] data_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [7:0]  rx_len_q;
  logic        rx_first_q;
  logic [7:0]  rsp_type_q;
  logic [7:0]  rsp_mshr_q;
  logic [63:0] rsp_data_q;
  logic        timeout_q;
  logic        err_q;

  logic        is_store;
  logic [63:0] hdr_flit;
  logic [7:0]  dec_len;
  logic [7:0]  dec_type;
  logic [7:0]  dec_mshr;
  logic        hdr_bad;

  assign is_store = type_q == MSG_STORE_REQ;
  assign cnt_d    = cnt_q + 16'd1;

  noc_hdr_codec #(
    .DEST_X(DEST_X),
    .DEST_Y(DEST_Y)
  ) u_codec (
    .enc_len_i   (req_len(is_store)),
    .enc_type_i  (type_q),
    .enc_mshrid_i(mshr_q),
    .hdr_o       (hdr_flit),
    .flit_i      (noc2_data),
    .dec_len_o   (dec_len),
    .dec_type_o  (dec_type),
    .dec_mshrid_o(dec_mshr)
  );

  // Replies longer than one data flit are drained but flagged.
  assign hdr_bad = (dec_mshr != mshr_q)
                || (dec_type != ack_type(is_store))
                || (dec_len > 8'd1);

  assign cmd_ready  = state_q == ST_IDLE;
  assign noc1_valid = (state_q == ST_TX_HDR)
                   || (state_q == ST_TX_ADDR)
                   || (state_q == ST_TX_DATA);
  assign noc2_ready = (state_q == ST_WAIT_HDR)
                   || (state_q == ST_RX_DATA);
  assign rsp_valid   = state_q == ST_DONE;
  assign rsp_type    = rsp_type_q;
  assign rsp_mshrid  = rsp_mshr_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = timeout_q;
  assign rsp_err     = err_q;

  // Flit sources are registers frozen while in TX, so a stalled
  // flit stays stable until accepted.
  always_comb begin
    noc1_data = '0;
    unique case (state_q)
      ST_TX_HDR:  noc1_data = hdr_flit;
      ST_TX_ADDR: noc1_data = {24'b0, addr_q};
      ST_TX_DATA: noc1_data = data_q;
      default:    noc1_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      type_q     <= '0;
      mshr_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      rx_len_q   <= '0;
      rx_first_q <= 1'b0;
      rsp_type_q <= '0;
      rsp_mshr_q <= '0;
      rsp_data_q <= '0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            type_q     <= cmd_type;
            mshr_q     <= cmd_mshrid;
            addr_q     <= cmd_addr;
            data_q     <= cmd_data;
            rsp_type_q <= '0;
            rsp_mshr_q <= '0;
            rsp_data_q <= '0;
            state_q    <= ST_TX_HDR;
          end
        end
        ST_TX_HDR: begin
          if (noc1_ready) state_q <= ST_TX_ADDR;
        end
        ST_TX_ADDR: begin
          if (noc1_ready) begin
            cnt_q   <= '0;
            state_q <= is_store ? ST_TX_DATA : ST_WAIT_HDR;
          end
        end
        ST_TX_DATA: begin
          if (noc1_ready) begin
            cnt_q   <= '0;
            state_q <= ST_WAIT_HDR;
          end
        end
        ST_WAIT_HDR: begin
          cnt_q <= cnt_d;
          if (noc2_valid) begin
            rsp_type_q <= dec_type;
            rsp_mshr_q <= dec_mshr;
            err_q      <= hdr_bad;
            rx_len_q   <= dec_len;
            rx_first_q <= 1'b1;
            state_q    <= (dec_len == 8'd0) ? ST_DONE : ST_RX_DATA;
          end else if (cnt_d == TO_LIMIT) begin
            timeout_q  <= 1'b1;
            rsp_type_q <= '0;
            rsp_mshr_q <= mshr_q;
            state_q    <= ST_DONE;
          end
        end
        ST_RX_DATA: begin
          if (noc2_valid) begin
            if (rx_first_q) rsp_data_q <= noc2_data;
            rx_first_q <= 1'b0;
            rx_len_q   <= rx_len_q - 8'd1;
            if (rx_len_q <= 8'd1) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_req_initiator.sv
// Directed bench for store_req_initiator: store, load, backpressure,
// timeout, header-at-expiry, error replies and mid-flight reset.
`timescale 1ns/1ps
module tb_store_req_initiator;

  localparam logic [7:0] T_ST   = 8'd2;
  localparam logic [7:0] T_LD   = 8'd31;
  localparam logic [7:0] T_DACK = 8'd36;
  localparam logic [7:0] T_NACK = 8'd37;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_type = '0;
  logic [39:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic [7:0]  cmd_mshrid = '0;
  logic        noc1_valid;
  logic [63:0] noc1_data;
  logic        noc1_ready = 1'b1;
  logic        noc2_valid = 1'b0;
  logic [63:0] noc2_data = '0;
  logic        noc2_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_type;
  logic [7:0]  rsp_mshrid;
  logic [63:0] rsp_data;
  logic        rsp_timeout;
  logic        rsp_err;

  int runs = 0;
  int fails = 0;

  store_req_initiator #(
    .TIMEOUT_CYCLES(8),
    .DEST_X(8'd3),
    .DEST_Y(8'd4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_mshrid(cmd_mshrid),
    .noc1_valid(noc1_valid), .noc1_data(noc1_data),
    .noc1_ready(noc1_ready),
    .noc2_valid(noc2_valid), .noc2_data(noc2_data),
    .noc2_ready(noc2_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_type(rsp_type), .rsp_mshrid(rsp_mshrid),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk_hdr(input logic [7:0] x,
      input logic [7:0] y, input logic [7:0] len,
      input logic [7:0] typ, input logic [7:0] mshr);
    logic [63:0] h;
    h = '0;
    h[63:56] = x;
    h[55:48] = y;
    h[29:22] = len;
    h[21:14] = typ;
    h[13:6]  = mshr;
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] t, input logic [39:0] a,
      input logic [63:0] d, input logic [7:0] m);
    cmd_type = t; cmd_addr = a; cmd_data = d; cmd_mshrid = m;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic reply(input logic [63:0] f);
    noc2_valid = 1'b1;
    noc2_data  = f;
    tick();
    noc2_valid = 1'b0;
    noc2_data  = '0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] c;
    rst = 1'b1;
    tick(); tick();
    c = {cmd_ready, noc1_valid, noc2_ready, rsp_valid, rsp_timeout, rsp_err};
    runs++; if (c !== 6'b100000) begin fails++; $display("FAIL reset_ctrl got %b want 100000", c); end
    runs++; if ({rsp_type, rsp_mshrid, rsp_data} !== 80'd0) begin fails++; $display("FAIL reset_rsp got %h/%h/%h want 0", rsp_type, rsp_mshrid, rsp_data); end
    runs++; if (noc1_data !== 64'd0) begin fails++; $display("FAIL reset_noc1 got %h want 0", noc1_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store();
    logic [63:0] e;
    issue(T_ST, 40'h12_3456_7880, 64'hDEAD_BEEF_0000_0001, 8'd5);
    e = mk_hdr(8'd3, 8'd4, 8'd2, T_ST, 8'd5);
    runs++; if ({cmd_ready, noc1_valid} !== 2'b01) begin fails++; $display("FAIL st_hdr_vld got %b want 01", {cmd_ready, noc1_valid}); end
    runs++; if (noc1_data !== e) begin fails++; $display("FAIL st_hdr got %h want %h", noc1_data, e); end
    tick();
    e = 64'h0000_0012_3456_7880;
    runs++; if ({noc1_valid, noc1_data} !== {1'b1, e}) begin fails++; $display("FAIL st_addr got %b/%h want 1/%h", noc1_valid, noc1_data, e); end
    tick();
    e = 64'hDEAD_BEEF_0000_0001;
    runs++; if ({noc1_valid, noc1_data} !== {1'b1, e}) begin fails++; $display("FAIL st_data got %b/%h want 1/%h", noc1_valid, noc1_data, e); end
    tick();
    runs++; if ({noc1_valid, noc2_ready, rsp_valid} !== 3'b010) begin fails++; $display("FAIL st_wait got %b want 010", {noc1_valid, noc2_ready, rsp_valid}); end
    reply(mk_hdr(8'd0, 8'd0, 8'd0, T_NACK, 8'd5));
    runs++; if ({rsp_valid, rsp_err, rsp_timeout, noc2_ready} !== 4'b1000) begin fails++; $display("FAIL st_done got %b want 1000", {rsp_valid, rsp_err, rsp_timeout, noc2_ready}); end
    runs++; if ({rsp_type, rsp_mshrid} !== {T_NACK, 8'd5}) begin fails++; $display("FAIL st_fields got %0d/%0d want 37/5", rsp_type, rsp_mshrid); end
    tick();
    runs++; if ({rsp_valid, rsp_type, rsp_mshrid} !== {1'b1, T_NACK, 8'd5}) begin fails++; $display("FAIL st_hold got %b/%0d/%0d want 1/37/5", rsp_valid, rsp_type, rsp_mshrid); end
    finish_rsp();
    runs++; if ({cmd_ready, rsp_valid} !== 2'b10) begin fails++; $display("FAIL st_idle got %b want 10", {cmd_ready, rsp_valid}); end
  endtask

  task automatic test_load();
    logic [63:0] e;
    issue(T_LD, 40'h00_0000_1000, 64'h0, 8'd9);
    e = mk_hdr(8'd3, 8'd4, 8'd1, T_LD, 8'd9);
    runs++; if (noc1_data !== e) begin fails++; $display("FAIL ld_hdr got %h want %h", noc1_data, e); end
    tick();
    runs++; if (noc1_data !== 64'h0000_0000_0000_1000) begin fails++; $display("FAIL ld_addr got %h want 1000", noc1_data); end
    tick();
    runs++; if ({noc1_valid, noc2_ready} !== 2'b01) begin fails++; $display("FAIL ld_wait got %b want 01", {noc1_valid, noc2_ready}); end
    reply(mk_hdr(8'd0, 8'd0, 8'd1, T_DACK, 8'd9));
    runs++; if ({noc2_ready, rsp_valid} !== 2'b10) begin fails++; $display("FAIL ld_rx got %b want 10", {noc2_ready, rsp_valid}); end
    reply(64'hA5A5_A5A5_A5A5_A5A5);
    runs++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin fails++; $display("FAIL ld_done got %b want 100", {rsp_valid, rsp_err, rsp_timeout}); end
    runs++; if (rsp_data !== 64'hA5A5_A5A5_A5A5_A5A5) begin fails++; $display("FAIL ld_data got %h want a5a5a5a5a5a5a5a5", rsp_data); end
    runs++; if ({rsp_type, rsp_mshrid} !== {T_DACK, 8'd9}) begin fails++; $display("FAIL ld_fields got %0d/%0d want 36/9", rsp_type, rsp_mshrid); end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    logic [63:0] ea;
    ea = 64'h0000_00AB_CDEF_0123;
    issue(T_ST, 40'hAB_CDEF_0123, 64'h0123_4567_89AB_CDEF, 8'd7);
    tick();
    noc1_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      runs++; if ({noc1_valid, noc1_data} !== {1'b1, ea}) begin fails++; $display("FAIL bp_hold%0d got %b/%h want 1/%h", i, noc1_valid, noc1_data, ea); end
      tick();
    end
    noc1_ready = 1'b1;
    runs++; if (noc1_data !== ea) begin fails++; $display("FAIL bp_release got %h want %h", noc1_data, ea); end
    tick();
    runs++; if ({noc1_valid, noc1_data} !== {1'b1, 64'h0123_4567_89AB_CDEF}) begin fails++; $display("FAIL bp_data got %b/%h want 1/0123456789abcdef", noc1_valid, noc1_data); end
    tick();
    runs++; if ({noc1_valid, noc2_ready} !== 2'b01) begin fails++; $display("FAIL bp_wait got %b want 01", {noc1_valid, noc2_ready}); end
    reply(mk_hdr(8'd0, 8'd0, 8'd0, T_NACK, 8'd7));
    runs++; if ({rsp_valid, rsp_err} !== 2'b10) begin fails++; $display("FAIL bp_done got %b want 10", {rsp_valid, rsp_err}); end
    finish_rsp();
  endtask

  task automatic test_timeout();
    int n;
    issue(T_LD, 40'h00_0000_2000, 64'h0, 8'd4);
    tick(); tick();
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    runs++; if (n !== 8) begin fails++; $display("FAIL to_cycles got %0d want 8", n); end
    runs++; if ({rsp_valid, rsp_timeout, rsp_err, rsp_type} !== {3'b110, 8'd0}) begin fails++; $display("FAIL to_flags got %b/%b/%b/%0d want 1/1/0/0", rsp_valid, rsp_timeout, rsp_err, rsp_type); end
    finish_rsp();
    runs++; if ({cmd_ready, rsp_timeout} !== 2'b10) begin fails++; $display("FAIL to_clear got %b want 10", {cmd_ready, rsp_timeout}); end
  endtask

  task automatic test_hdr_at_expiry();
    issue(T_LD, 40'h00_0000_3000, 64'h0, 8'd3);
    tick(); tick();
    repeat (7) tick();
    runs++; if ({rsp_valid, noc2_ready} !== 2'b01) begin fails++; $display("FAIL exp_pre got %b want 01", {rsp_valid, noc2_ready}); end
    reply(mk_hdr(8'd0, 8'd0, 8'd0, T_DACK, 8'd3));
    runs++; if ({rsp_valid, rsp_timeout, rsp_err, rsp_type} !== {3'b100, T_DACK}) begin fails++; $display("FAIL exp_hdr got %b/%b/%b/%0d want 1/0/0/36", rsp_valid, rsp_timeout, rsp_err, rsp_type); end
    finish_rsp();
  endtask

  task automatic test_errors();
    issue(T_ST, 40'h00_0000_4000, 64'h55, 8'd5);
    tick(); tick(); tick();
    reply(mk_hdr(8'd0, 8'd0, 8'd0, T_NACK, 8'd6));
    runs++; if ({rsp_valid, rsp_err, rsp_mshrid} !== {2'b11, 8'd6}) begin fails++; $display("FAIL err_mshr got %b/%b/%0d want 1/1/6", rsp_valid, rsp_err, rsp_mshrid); end
    finish_rsp();
    runs++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", rsp_err); end
    issue(T_ST, 40'h00_0000_5000, 64'h66, 8'd2);
    tick(); tick(); tick();
    reply(mk_hdr(8'd0, 8'd0, 8'd0, T_DACK, 8'd2));
    runs++; if ({rsp_valid, rsp_err} !== 2'b11) begin fails++; $display("FAIL err_type got %b want 11", {rsp_valid, rsp_err}); end
    finish_rsp();
    issue(T_LD, 40'h00_0000_6000, 64'h0, 8'd1);
    tick(); tick();
    reply(mk_hdr(8'd0, 8'd0, 8'd2, T_DACK, 8'd1));
    reply(64'h1111_1111_1111_1111);
    runs++; if ({rsp_valid, noc2_ready} !== 2'b01) begin fails++; $display("FAIL extra_drain got %b want 01", {rsp_valid, noc2_ready}); end
    reply(64'h2222_2222_2222_2222);
    runs++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 64'h1111_1111_1111_1111}) begin fails++; $display("FAIL extra_done got %b/%b/%h want 1/1/1111111111111111", rsp_valid, rsp_err, rsp_data); end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    issue(T_ST, 40'h00_0000_7000, 64'h77, 8'd8);
    tick(); tick();
    runs++; if ({noc1_valid, noc1_data} !== {1'b1, 64'h77}) begin fails++; $display("FAIL rm_txdata got %b/%h want 1/77", noc1_valid, noc1_data); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    runs++; if ({noc1_valid, cmd_ready, noc2_ready, rsp_valid} !== 4'b0100) begin fails++; $display("FAIL rm_abort got %b want 0100", {noc1_valid, cmd_ready, noc2_ready, rsp_valid}); end
    tick(); tick();
    runs++; if ({noc1_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL rm_quiet got %b want 01", {noc1_valid, cmd_ready}); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_backpressure();
    test_timeout();
    test_hdr_at_expiry();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule

// File: doc/store_req_initiator.md
STORE_REQ_INITIATOR -- requirements
Module: store_req_initiator

Interface
REQ-001 Parameters (name, default, meaning): TIMEOUT_CYCLES, 256, cycles allowed between last request flit and response header; DEST_X, 0, L2 tile x; DEST_Y, 0, L2 tile y.
REQ-002 clk  in  1  clock; all state changes on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid / cmd_ready  in / out  1  command handshake; transfer when both high.
REQ-005 cmd_type  in  8  MSG_STORE_REQ or MSG_LOAD_REQ.
REQ-006 cmd_addr  in  40  physical line address.
REQ-007 cmd_data  in  64  store data; ignored for loads.
REQ-008 cmd_mshrid  in  8  requester tag.
REQ-009 noc1_valid / noc1_data  out  1 / 64  request flits to L2.
REQ-010 noc1_ready  in  1  L2 accepts flit when noc1_valid and noc1_ready both high.
REQ-011 noc2_valid / noc2_data  in  1 / 64  response flits from L2.
REQ-012 noc2_ready  out  1  initiator accepts response flit.
REQ-013 rsp_valid / rsp_ready  out / in  1  completion handshake.
REQ-014 rsp_type, rsp_mshrid, rsp_data  out  8, 8, 64  response fields.
REQ-015 rsp_timeout, rsp_err  out  1, 1  no response in time; mshrid mismatch or unexpected type.

Function
REQ-016 Header flit layout: [63:56] DEST_X, [55:48] DEST_Y, [29:22] payload length, [21:14] type, [13:6] mshrid, all other bits 0.
REQ-017 FSM states: IDLE, TX_HDR, TX_ADDR, TX_DATA, WAIT_HDR, RX_DATA, DONE.
REQ-018 IDLE: cmd_ready=1; accepted command latched into registers; next state TX_HDR.
REQ-019 TX_HDR: noc1_valid=1, header with length 2 for store, 1 for load; advance on noc1_ready.
REQ-020 TX_ADDR: flit {24'b0, addr}; on accept go to TX_DATA for store, WAIT_HDR for load.
REQ-021 TX_DATA: flit = latched data; on accept go to WAIT_HDR.
REQ-022 noc1_data SHALL hold stable while noc1_valid is high and noc1_ready is low.
REQ-023 WAIT_HDR and RX_DATA: noc2_ready=1; noc2_ready=0 in all other states.
REQ-024 WAIT_HDR on header: capture type and mshrid; length 0 goes to DONE, otherwise RX_DATA.
REQ-025 RX_DATA: first data flit captured into rsp_data; go to DONE; extra flits beyond length 1 are consumed and discarded, and rsp_err is set.
REQ-026 rsp_err=1 when header mshrid differs from latched mshrid, or type is not MSG_DATA_ACK (load) / MSG_NODATA_ACK (store).
REQ-027 Timeout counter is 16 bits: cleared on entry to WAIT_HDR and incremented each WAIT_HDR cycle; reaching TIMEOUT_CYCLES goes to DONE with rsp_timeout=1 and rsp_type=0.
REQ-028 A header arriving in the same cycle as expiry takes priority over the timeout.
REQ-029 DONE: rsp_valid=1 with fields stable until rsp_ready; then go to IDLE and clear rsp_timeout/rsp_err.
REQ-030 Exactly one request is outstanding; cmd_ready=0 outside IDLE.
REQ-031 Minimum store latency, accept to rsp_valid: 3 tx cycles + 1 header cycle + 1 cycle, with zero backpressure.

Reset
REQ-032 rst SHALL force IDLE, cmd_ready=1, noc1_valid=0, noc2_ready=0, rsp_valid=0, counter=0, rsp_timeout=0, rsp_err=0, and all data registers to 0.
REQ-033 rst asserted mid-transaction SHALL abandon it with no further flits; rst has priority over every other event.

Structure
REQ-034 Shared package pmesh_msg_pkg holds MSG_STORE_REQ=8'd2, MSG_LOAD_REQ=8'd31, MSG_DATA_ACK=8'd36, MSG_NODATA_ACK=8'd37, header field offsets, and the state enum.
REQ-035 One sub-module, noc_hdr_codec, SHALL be combinational and encode/decode header fields; FSM and datapath stay in store_req_initiator.

Verification
REQ-036 Store: addr=40'h12_3456_7880, data=64'hDEAD_BEEF_0000_0001, mshrid=5, no backpressure -> flits hdr(len2,type2,mshr5), addr, data; NODATA_ACK mshr5 -> rsp_valid with err=0 and timeout=0.
REQ-037 Load: mshrid=9; response DATA_ACK len1 mshr9 plus data 64'hA5A5... -> rsp_data=64'hA5A5..., rsp_type=36.
REQ-038 noc1_ready low for 4 cycles during TX_ADDR -> noc1_data constant for those cycles and no flit lost or duplicated.
REQ-039 No response, TIMEOUT_CYCLES=8 -> rsp_valid with rsp_timeout=1 exactly 8 cycles after WAIT_HDR entry.
REQ-040 Response mshrid=6 when 5 is expected -> rsp_err=1; then rst in TX_DATA on the next command -> noc1_valid=0 next cycle and state IDLE.
